montgomery_mult: RTL and testbench

MONTGOMERY_MULT -- requirements
Module: montgomery_mult

---
 rtl/montgomery_mult.sv | 108 ++++++++++
 tb/tb_montgomery_mult.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/montgomery_mult.sv
// rtl/montgomery_mult.sv - fixed-latency Montgomery multiplier, P = A*B*R^-1 mod N
// Six-state pipeline FSM; operands are latched on start so inputs may change mid-operation.
module montgomery_mult #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [BITS-1:0] N,
  input  logic [BITS-1:0] N_prime,
  output logic [BITS-1:0] P,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {IDLE, MUL, RED, ADD, SUB, FIN} state_t;

  state_t state_q;

  logic [BITS-1:0]   a_q, b_q, n_q, np_q;
  logic [2*BITS-1:0] T;
  logic [BITS-1:0]   m;
  logic [2*BITS-1:0] m_mult_N;
  logic [2*BITS:0]   t_temp;
  logic [BITS:0]     t_temp2;
  logic [BITS:0]     t_final;

  logic [2*BITS-1:0] mn_full;
  logic [BITS:0]     shifted;
  logic [BITS:0]     reduced;

  // t_temp carries one extra bit, so the shifted value can reach R and still be reduced.
  always_comb begin
    mn_full = {{BITS{1'b0}}, m} * {{BITS{1'b0}}, n_q};
    shifted = t_temp[2*BITS:BITS];
    reduced = (shifted >= {1'b0, n_q}) ? (shifted - {1'b0, n_q}) : shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      np_q     <= '0;
      T        <= '0;
      m        <= '0;
      m_mult_N <= '0;
      t_temp   <= '0;
      t_temp2  <= '0;
      t_final  <= '0;
      P        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            n_q     <= N;
            np_q    <= N_prime;
            busy    <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          T       <= {{BITS{1'b0}}, a_q} * {{BITS{1'b0}}, b_q};
          state_q <= RED;
        end
        RED: begin
          m       <= T[BITS-1:0] * np_q;
          state_q <= ADD;
        end
        ADD: begin
          m_mult_N <= mn_full;
          t_temp   <= {1'b0, T} + {1'b0, mn_full};
          state_q  <= SUB;
        end
        SUB: begin
          t_temp2 <= shifted;
          t_final <= reduced;
          state_q <= FIN;
        end
        FIN: begin
          P       <= t_final[BITS-1:0];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  a_low_zero: assert property (@(posedge clk) disable iff (!rst_n)
    t_temp[BITS-1:0] == '0);

  a_sum_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == SUB) |-> (t_temp == ({1'b0, T} + {1'b0, m_mult_N})));

endmodule

// File: tb/tb_montgomery_mult.sv
// tb/tb_montgomery_mult.sv - directed and model-checked bench for montgomery_mult
module tb_montgomery_mult;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A, B, N, N_prime;
  logic [31:0] P;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  montgomery_mult #(.BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B), .N(N), .N_prime(N_prime),
    .P(P), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a, b, n, np;
    logic [31:0] p, m;
    logic [32:0] tt2;
    logic [64:0] tt;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Independent reference: reduce A*B mod N, then divide by 2 BITS times modulo N.
  function automatic logic [31:0] ref_mont(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] n);
    logic [63:0] x;
    x = (64'(a) * 64'(b)) % 64'(n);
    for (int i = 0; i < 32; i++)
      x = x[0] ? ((x + 64'(n)) >> 1) : (x >> 1);
    return x[31:0];
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                        input logic [31:0] np, output logic [31:0] p, output int lat);
    A = a; B = b; N = n; N_prime = np; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; N = $urandom; N_prime = $urandom;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    p = P;
  endtask

  logic [31:0] p_got, rn, ra, rb;
  int          lat, dcount, bad_lat;
  int          dpos[$];

  initial begin
    vecs[0] = '{"zero",   32'd0,          32'd5,          32'hFFFFFFFF, 32'd1,
                32'd0,  32'd0,          33'd0,          65'd0};
    vecs[1] = '{"trivial", 32'd5,         32'd7,          32'hFFFFFFFF, 32'd1,
                32'd35, 32'd35,         33'd35,         65'd150323855360};
    vecs[2] = '{"small",  32'd2,          32'd2,          32'd3,        32'd1431655765,
                32'd1,  32'd1431655764, 33'd1,          65'd4294967296};
    vecs[3] = '{"carry",  32'd4294967294, 32'd4294967294, 32'hFFFFFFFF, 32'd1,
                32'd1,  32'd4,          33'h1_0000_0000, 65'h1_0000_0000_0000_0000};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; N = '0; N_prime = '0;
    repeat (2) @(negedge clk);
    check("rst_P", 65'(P), 65'd0);
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_done", 65'(done), 65'd0);
    check("rst_T", 65'(dut.T), 65'd0);
    check("rst_t_temp", dut.t_temp, 65'd0);
    rst_n = 1'b1;

    // First vector starts on the very first edge after reset release.
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].np, p_got, lat);
      check({vecs[i].name, "_P"}, 65'(p_got), 65'(vecs[i].p));
      check({vecs[i].name, "_latency"}, 65'(lat), 65'd6);
      check({vecs[i].name, "_m"}, 65'(dut.m), 65'(vecs[i].m));
      check({vecs[i].name, "_t_temp2"}, 65'(dut.t_temp2), 65'(vecs[i].tt2));
      check({vecs[i].name, "_t_temp"}, dut.t_temp, vecs[i].tt);
    end
    @(negedge clk);
    check("done_one_cycle", 65'(done), 65'd0);
    repeat (3) @(negedge clk);
    check("P_hold", 65'(P), 65'd1);

    rn = 32'd4292870399;
    run_op(32'd3797488404, 32'd3797488404, rn, 32'd3235971329, p_got, lat);
    check("rand_first", 65'(p_got), 65'(ref_mont(32'd3797488404, 32'd3797488404, rn)));
    bad_lat = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom % rn;
      rb = $urandom % rn;
      run_op(ra, rb, rn, 32'd3235971329, p_got, lat);
      if (lat != 6) bad_lat++;
      check("rand_vec", 65'(p_got), 65'(ref_mont(ra, rb, rn)));
    end
    check("rand_latency_errors", 65'(bad_lat), 65'd0);

    // start held 20 cycles: results at cycles 6, 12, 18 within the window.
    A = 32'd5; B = 32'd7; N = 32'hFFFFFFFF; N_prime = 32'd1; start = 1'b1;
    dpos.delete();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) dpos.push_back(k);
    end
    start = 1'b0;
    check("hold_done_count", 65'(dpos.size()), 65'd3);
    if (dpos.size() == 3) begin
      check("hold_spacing1", 65'(dpos[1] - dpos[0]), 65'd6);
      check("hold_spacing2", 65'(dpos[2] - dpos[1]), 65'd6);
    end
    repeat (8) @(negedge clk);
    check("hold_idle_busy", 65'(busy), 65'd0);
    check("hold_P", 65'(P), 65'd35);

    // Abort mid-operation: P currently holds 35 and must be cleared.
    A = 32'd2; B = 32'd2; N = 32'd3; N_prime = 32'd1431655765; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 65'(busy), 65'd1);
    rst_n = 1'b0;
    #1;
    check("abort_P", 65'(P), 65'd0);
    check("abort_busy", 65'(busy), 65'd0);
    check("abort_done", 65'(done), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 65'(dcount), 65'd0);
    run_op(32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, p_got, lat);
    check("after_abort_P", 65'(p_got), 65'd35);
    check("after_abort_latency", 65'(lat), 65'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
